// File: rtl/multiexp_dispatch_reduce_pkg.sv
// Shared types for the multiexp dispatch/reduce block: controller states,
// point/scalar pair layout and the per-item control bits from the dispatcher.
package multiexp_dispatch_reduce_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COLLECT,
    ST_REDUCE,
    ST_OUT
  } state_t;

  // A pair is packed {point, scalar}: the point occupies the upper bits.
  localparam int unsigned DEF_PNT_BITS = 768;
  localparam int unsigned DEF_SCL_BITS = 256;

  typedef logic [DEF_PNT_BITS-1:0] pnt_t;
  typedef logic [DEF_SCL_BITS-1:0] scl_t;

  typedef struct packed {
    pnt_t pnt;
    scl_t scl;
  } pair_t;

  // Control bits the dispatcher reports for the item currently offered.
  typedef struct packed {
    logic last;  // item N-1 of the batch
    logic eop;   // final item this core will receive
  } dsp_ctl_t;

  function automatic int unsigned active_cores(input int unsigned n, input int unsigned cores);
    return (n < cores) ? n : cores;
  endfunction

endpackage

// File: rtl/multiexp_dispatch_reduce_rr_dispatch.sv
// Round-robin dispatcher: tracks item count and target core for a batch and
// flags the per-core last item and the batch-final item.
module multiexp_rr_dispatch
  import multiexp_dispatch_reduce_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned NUM_IN_MAX = 1024,
  localparam int unsigned NI_W = $clog2(NUM_IN_MAX + 1),
  localparam int unsigned CI_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int unsigned AC_W = $clog2(NUM_CORES + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            start,
  input  logic [NI_W-1:0] num_in,
  input  logic            advance,
  input  logic            clear,
  output logic [CI_W-1:0] target,
  output logic [AC_W-1:0] act,
  output dsp_ctl_t        ctl
);

  logic [NI_W-1:0] n_reg;
  logic [NI_W-1:0] cnt_reg;
  logic [CI_W-1:0] tgt_reg;
  logic [AC_W-1:0] act_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      n_reg   <= '0;
      cnt_reg <= '0;
      tgt_reg <= '0;
      act_reg <= '0;
    end else if (start) begin
      n_reg   <= num_in;
      cnt_reg <= '0;
      tgt_reg <= '0;
      act_reg <= AC_W'(active_cores(32'(num_in), NUM_CORES));
    end else if (advance) begin
      cnt_reg <= cnt_reg + NI_W'(1);
      // Explicit wrap so non-power-of-2 core counts stay strictly round robin.
      tgt_reg <= (tgt_reg == CI_W'(NUM_CORES - 1)) ? '0 : tgt_reg + CI_W'(1);
    end
  end

  assign target   = tgt_reg;
  assign act      = act_reg;
  // The last ACT items of the batch are each core's final item.
  assign ctl.eop  = (cnt_reg >= (n_reg - NI_W'(act_reg)));
  assign ctl.last = (cnt_reg == (n_reg - NI_W'(1)));

endmodule

// File: rtl/multiexp_dispatch_reduce.sv
// Batch controller: deals point-scalar pairs round robin to the multiexp cores,
// then folds the per-core results through an external point adder.
module multiexp_dispatch_reduce
  import multiexp_dispatch_reduce_pkg::*;
#(
  parameter int unsigned NUM_CORES  = 4,
  parameter int unsigned PNT_BITS   = 768,
  parameter int unsigned SCL_BITS   = 256,
  parameter int unsigned NUM_IN_MAX = 1024,
  localparam int unsigned NI_W  = $clog2(NUM_IN_MAX + 1),
  localparam int unsigned DAT_W = PNT_BITS + SCL_BITS,
  localparam int unsigned CI_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int unsigned AC_W  = $clog2(NUM_CORES + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NI_W-1:0]               i_num_in,
  input  logic                          i_val,
  output logic                          o_rdy,
  input  logic [DAT_W-1:0]              i_dat,
  input  logic                          i_eop,
  output logic [NUM_CORES-1:0]          o_core_val,
  output logic [DAT_W-1:0]              o_core_dat,
  output logic                          o_core_eop,
  input  logic [NUM_CORES-1:0]          i_core_rdy,
  input  logic [NUM_CORES-1:0]          i_res_val,
  input  logic [NUM_CORES*PNT_BITS-1:0] i_res_dat,
  output logic [NUM_CORES-1:0]          o_res_rdy,
  output logic                          o_add_val,
  output logic [2*PNT_BITS-1:0]         o_add_dat,
  input  logic                          i_add_rdy,
  input  logic                          i_add_val,
  input  logic [PNT_BITS-1:0]           i_add_dat,
  output logic                          o_add_rdy,
  output logic                          o_val,
  output logic [PNT_BITS-1:0]           o_dat,
  output logic                          o_err,
  input  logic                          i_rdy
);

  state_t              state_reg, state_next;
  logic [PNT_BITS-1:0] acc_reg;
  logic [PNT_BITS-1:0] opnd_reg;
  logic                err_reg;
  logic                issued_reg;
  logic [CI_W-1:0]     res_idx_reg;

  logic [CI_W-1:0]     target;
  logic [AC_W-1:0]     act;
  dsp_ctl_t            ctl;
  logic                start, in_fire, res_fire, add_req_fire, add_res_fire, out_fire;
  logic                res_last;
  logic [PNT_BITS-1:0] res_pnt;

  assign start        = (state_reg == ST_IDLE) && i_val && (i_num_in != '0);
  assign o_rdy        = (state_reg == ST_LOAD) && i_core_rdy[target];
  assign in_fire      = o_rdy && i_val;
  assign res_pnt      = i_res_dat[res_idx_reg*PNT_BITS +: PNT_BITS];
  assign res_fire     = (state_reg == ST_COLLECT) && i_res_val[res_idx_reg];
  assign add_req_fire = o_add_val && i_add_rdy;
  assign add_res_fire = o_add_rdy && i_add_val;
  assign out_fire     = o_val && i_rdy;
  assign res_last     = ((AC_W'(res_idx_reg) + AC_W'(1)) == act);

  multiexp_rr_dispatch #(
    .NUM_CORES (NUM_CORES),
    .NUM_IN_MAX(NUM_IN_MAX)
  ) u_dispatch (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .start  (start),
    .num_in (i_num_in),
    .advance(in_fire),
    .clear  (out_fire),
    .target (target),
    .act    (act),
    .ctl    (ctl)
  );

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    assign o_core_val[gi] = (state_reg == ST_LOAD) && i_val && (target == CI_W'(gi));
    assign o_res_rdy[gi]  = (state_reg == ST_COLLECT) && (res_idx_reg == CI_W'(gi));
  end

  assign o_core_dat = (state_reg == ST_LOAD) ? i_dat : '0;
  assign o_core_eop = (state_reg == ST_LOAD) && i_val && ctl.eop;
  assign o_add_val  = (state_reg == ST_REDUCE) && !issued_reg;
  assign o_add_rdy  = (state_reg == ST_REDUCE) && issued_reg;
  assign o_add_dat  = (state_reg == ST_REDUCE) ? {acc_reg, opnd_reg} : '0;
  assign o_val      = (state_reg == ST_OUT);
  assign o_dat      = (state_reg == ST_OUT) ? acc_reg : '0;
  assign o_err      = (state_reg == ST_OUT) && err_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_LOAD;
      ST_LOAD:    if (in_fire && ctl.last) state_next = ST_COLLECT;
      ST_COLLECT: begin
        if (res_fire) begin
          if (res_idx_reg != '0)       state_next = ST_REDUCE;
          else if (act == AC_W'(1))    state_next = ST_OUT;
        end
      end
      ST_REDUCE:  if (add_res_fire) state_next = res_last ? ST_OUT : ST_COLLECT;
      ST_OUT:     if (i_rdy) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      acc_reg     <= '0;
      opnd_reg    <= '0;
      err_reg     <= 1'b0;
      issued_reg  <= 1'b0;
      res_idx_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Framing errors are sticky but never stop the item count.
      if (in_fire && (i_eop != ctl.last)) err_reg <= 1'b1;
      if (res_fire) begin
        if (res_idx_reg == '0) begin
          acc_reg     <= res_pnt;
          res_idx_reg <= CI_W'(1);
        end else begin
          opnd_reg <= res_pnt;
        end
      end
      if (add_req_fire) issued_reg <= 1'b1;
      if (add_res_fire) begin
        acc_reg     <= i_add_dat;
        issued_reg  <= 1'b0;
        res_idx_reg <= res_idx_reg + CI_W'(1);
      end
      if (out_fire) begin
        err_reg     <= 1'b0;
        res_idx_reg <= '0;
      end
    end
  end

endmodule

// File: tb/tb_multiexp_dispatch_reduce.sv
// Bench for multiexp_dispatch_reduce: table of batches driven through modelled
// cores and adder, with scoreboards for core items, add operands and results.
module tb_multiexp_dispatch_reduce;

  localparam int NC = 3;
  localparam int PW = 16;
  localparam int SW = 8;
  localparam int NMAX = 32;
  localparam int DW = PW + SW;
  localparam int NI_W = $clog2(NMAX + 1);
  localparam int ADD_LAT = 2;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [NI_W-1:0]   i_num_in;
  logic              i_val;
  logic              o_rdy;
  logic [DW-1:0]     i_dat;
  logic              i_eop;
  logic [NC-1:0]     o_core_val;
  logic [DW-1:0]     o_core_dat;
  logic              o_core_eop;
  logic [NC-1:0]     i_core_rdy;
  logic [NC-1:0]     i_res_val;
  logic [NC*PW-1:0]  i_res_dat;
  logic [NC-1:0]     o_res_rdy;
  logic              o_add_val;
  logic [2*PW-1:0]   o_add_dat;
  logic              i_add_rdy;
  logic              i_add_val;
  logic [PW-1:0]     i_add_dat;
  logic              o_add_rdy;
  logic              o_val;
  logic [PW-1:0]     o_dat;
  logic              o_err;
  logic              i_rdy;

  multiexp_dispatch_reduce #(
    .NUM_CORES(NC), .PNT_BITS(PW), .SCL_BITS(SW), .NUM_IN_MAX(NMAX)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_num_in(i_num_in), .i_val(i_val), .o_rdy(o_rdy),
    .i_dat(i_dat), .i_eop(i_eop), .o_core_val(o_core_val), .o_core_dat(o_core_dat),
    .o_core_eop(o_core_eop), .i_core_rdy(i_core_rdy), .i_res_val(i_res_val),
    .i_res_dat(i_res_dat), .o_res_rdy(o_res_rdy), .o_add_val(o_add_val),
    .o_add_dat(o_add_dat), .i_add_rdy(i_add_rdy), .i_add_val(i_add_val),
    .i_add_dat(i_add_dat), .o_add_rdy(o_add_rdy), .o_val(o_val), .o_dat(o_dat),
    .o_err(o_err), .i_rdy(i_rdy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [DW-1:0] dat; logic eop; } citem_t;
  typedef struct packed { logic [PW-1:0] dat; logic err; } ores_t;
  typedef struct {
    int   n;
    int   eop_mode;    // 0 clean, 1 extra eop at bad_k, 2 no eop at all
    int   bad_k;
    int   stall_core;
    int   stall_cyc;
    int   out_hold;
    logic exp_err;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  citem_t          core_q[NC][$];
  logic [2*PW-1:0] add_q[$];
  ores_t           out_q[$];
  logic [PW-1:0]   core_sum[NC];
  int              act_m, res_exp, adds_done, fin_cyc, add_pend, outs_done;
  logic [PW-1:0]   add_sum;
  logic            in_fire, prev_val, s_val, s_rdy, s_addv;
  logic [PW-1:0]   s_dat;
  logic [7:0]      s_ctl;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // One clock: observe handshakes at the falling edge, update responders after the rising edge.
  task automatic tick();
    logic [NC-1:0] res_fire;
    logic          addres_fire;
    citem_t        ci;
    ores_t         eo;
    @(negedge i_clk);
    cyc++;
    s_rdy  = o_rdy;
    s_val  = o_val;
    s_dat  = o_dat;
    s_addv = o_add_val;
    s_ctl  = {o_rdy, |o_core_val, o_core_eop, |o_res_rdy, o_add_val, o_add_rdy, o_val, o_err};
    in_fire = i_val && o_rdy;
    for (int c = 0; c < NC; c++) begin
      if (o_core_val[c] && i_core_rdy[c]) begin
        if (core_q[c].size() == 0) chk("core_unexpected_item", 64'(c), 64'hFF);
        else begin
          ci = core_q[c].pop_front();
          chk("core_item", {o_core_dat, o_core_eop}, ci);
        end
      end
    end
    res_fire = o_res_rdy & i_res_val;
    for (int c = 0; c < NC; c++) begin
      if (res_fire[c]) begin
        chk("res_order", 64'(c), 64'(res_exp));
        chk("res_core_active", 64'(c < act_m), 64'd1);
        res_exp++;
        if (act_m == 1) fin_cyc = cyc;
      end
    end
    if (o_add_val && i_add_rdy) begin
      if (add_q.size() == 0) chk("add_unexpected", 64'd1, 64'd0);
      else chk("add_operands", o_add_dat, add_q.pop_front());
      add_pend = ADD_LAT;
      add_sum  = o_add_dat[2*PW-1:PW] + o_add_dat[PW-1:0];
    end
    addres_fire = o_add_rdy && i_add_val;
    if (addres_fire) begin
      adds_done++;
      if (adds_done == act_m - 1) fin_cyc = cyc;
    end
    if (o_val && !prev_val) chk("out_latency", 64'(cyc), 64'(fin_cyc + 1));
    prev_val = o_val;
    if (o_val && i_rdy) begin
      if (out_q.size() == 0) chk("out_unexpected", 64'd1, 64'd0);
      else begin
        eo = out_q.pop_front();
        chk("out_dat", o_dat, eo.dat);
        chk("out_err", o_err, eo.err);
        $display("batch result dat=%h err=%0d cycle=%0d", o_dat, o_err, cyc);
      end
      outs_done++;
    end
    @(posedge i_clk);
    #1;
    i_res_val = i_res_val & ~res_fire;
    if (addres_fire) i_add_val = 1'b0;
    if (add_pend > 0) begin
      add_pend--;
      if (add_pend == 0) begin
        i_add_val = 1'b1;
        i_add_dat = add_sum;
      end
    end
  endtask

  task automatic drive_item(input vec_t v, input int k);
    logic [PW-1:0] p;
    logic [SW-1:0] s;
    p = PW'($urandom);
    s = SW'($urandom);
    i_dat = {p, s};
    case (v.eop_mode)
      1:       i_eop = (k == v.n - 1) || (k == v.bad_k);
      2:       i_eop = 1'b0;
      default: i_eop = (k == v.n - 1);
    endcase
    core_q[k % NC].push_back('{dat: {p, s}, eop: (k >= v.n - act_m)});
    core_sum[k % NC] = core_sum[k % NC] + p;
  endtask

  task automatic load_batch(input vec_t v);
    int k, guard;
    logic stalled;
    act_m = (v.n < NC) ? v.n : NC;
    res_exp = 0; adds_done = 0; fin_cyc = -100;
    for (int c = 0; c < NC; c++) core_sum[c] = '0;
    i_num_in = NI_W'(v.n);
    i_val = 1'b1;
    k = 0; guard = 0; stalled = 1'b0;
    drive_item(v, 0);
    while (k < v.n && guard < 1000) begin
      if (v.stall_cyc > 0 && !stalled && k == v.stall_core) begin
        stalled = 1'b1;
        i_core_rdy[v.stall_core] = 1'b0;
        for (int s = 0; s < v.stall_cyc; s++) begin
          tick();
          chk("stall_rdy_low", s_rdy, 1'b0);
          if (in_fire) begin k++; if (k < v.n) drive_item(v, k); end
        end
        i_core_rdy = '1;
      end
      tick();
      guard++;
      if (in_fire) begin k++; if (k < v.n) drive_item(v, k); end
    end
    i_val = 1'b0;
    i_eop = 1'b0;
    chk("load_count", 64'(k), 64'(v.n));
  endtask

  task automatic raise_results(input vec_t v);
    logic [PW-1:0] part;
    for (int c = 0; c < NC; c++)
      i_res_dat[c*PW +: PW] = (c < act_m) ? core_sum[c] : (PW'(16'hBEEF) ^ PW'(c));
    i_res_val = '1;
    part = core_sum[0];
    for (int i = 1; i < act_m; i++) begin
      add_q.push_back({part, core_sum[i]});
      part = part + core_sum[i];
    end
    out_q.push_back('{dat: part, err: v.exp_err});
  endtask

  task automatic finish_batch(input vec_t v);
    int start_outs, guard, qsz;
    logic [PW-1:0] d0;
    start_outs = outs_done;
    guard = 0;
    if (v.out_hold > 0) begin
      i_rdy = 1'b0;
      do begin tick(); guard++; end while (!s_val && guard < 500);
      chk("out_seen", s_val, 1'b1);
      d0 = s_dat;
      i_val = 1'b1;  // try to start a new batch while the result is pending
      for (int h = 0; h < v.out_hold; h++) begin
        tick();
        chk("hold_val", s_val, 1'b1);
        chk("hold_dat", s_dat, d0);
        chk("hold_no_rdy", s_rdy, 1'b0);
      end
      i_val = 1'b0;
      i_rdy = 1'b1;
    end
    guard = 0;
    while (outs_done == start_outs && guard < 500) begin tick(); guard++; end
    chk("out_count", 64'(outs_done - start_outs), 64'd1);
    i_res_val = '0;
    tick();
    qsz = add_q.size() + out_q.size();
    for (int c = 0; c < NC; c++) qsz += core_q[c].size();
    chk("queues_drained", 64'(qsz), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    load_batch(v);
    raise_results(v);
    finish_batch(v);
  endtask

  vec_t tbl[9];
  vec_t rv;
  int   guard;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{n: 7,  eop_mode: 0, bad_k: 0, stall_core: 0, stall_cyc: 0,  out_hold: 0, exp_err: 1'b0};
    tbl[1] = '{n: 2,  eop_mode: 0, bad_k: 0, stall_core: 0, stall_cyc: 0,  out_hold: 0, exp_err: 1'b0};
    tbl[2] = '{n: 6,  eop_mode: 0, bad_k: 0, stall_core: 1, stall_cyc: 10, out_hold: 0, exp_err: 1'b0};
    tbl[3] = '{n: 8,  eop_mode: 1, bad_k: 3, stall_core: 0, stall_cyc: 0,  out_hold: 0, exp_err: 1'b1};
    tbl[4] = '{n: 4,  eop_mode: 0, bad_k: 0, stall_core: 0, stall_cyc: 0,  out_hold: 0, exp_err: 1'b0};
    tbl[5] = '{n: 1,  eop_mode: 0, bad_k: 0, stall_core: 0, stall_cyc: 0,  out_hold: 0, exp_err: 1'b0};
    tbl[6] = '{n: 5,  eop_mode: 2, bad_k: 0, stall_core: 0, stall_cyc: 0,  out_hold: 0, exp_err: 1'b1};
    tbl[7] = '{n: 3,  eop_mode: 0, bad_k: 0, stall_core: 0, stall_cyc: 0,  out_hold: 5, exp_err: 1'b0};
    tbl[8] = '{n: 32, eop_mode: 0, bad_k: 0, stall_core: 0, stall_cyc: 0,  out_hold: 0, exp_err: 1'b0};

    i_rst = 1'b1; i_num_in = NI_W'(5); i_val = 1'b1; i_dat = '0; i_eop = 1'b0;
    i_core_rdy = '1; i_res_val = '0; i_res_dat = '0; i_add_rdy = 1'b1;
    i_add_val = 1'b0; i_add_dat = '0; i_rdy = 1'b1;
    add_pend = 0; outs_done = 0; prev_val = 1'b0; act_m = 1; res_exp = 0;
    adds_done = 0; fin_cyc = -100;

    tick();
    tick();
    chk("reset_outputs", s_ctl, 8'h00);
    i_val = 1'b0;
    i_rst = 1'b0;
    tick();
    chk("idle_outputs", s_ctl, 8'h00);

    foreach (tbl[i]) begin
      $display("vector %0d: n=%0d eop_mode=%0d stall=%0d hold=%0d", i, tbl[i].n,
               tbl[i].eop_mode, tbl[i].stall_cyc, tbl[i].out_hold);
      run_vec(tbl[i]);
    end

    // Reset while an add is outstanding, then a clean batch must still work.
    rv = '{n: 4, eop_mode: 0, bad_k: 0, stall_core: 0, stall_cyc: 0, out_hold: 0, exp_err: 1'b0};
    load_batch(rv);
    raise_results(rv);
    guard = 0;
    do begin tick(); guard++; end while (!s_addv && guard < 200);
    chk("reached_reduce", s_addv, 1'b1);
    i_rst = 1'b1;
    i_res_val = '0; i_add_val = 1'b0; i_add_rdy = 1'b0; add_pend = 0;
    tick();
    i_rst = 1'b0;
    add_q.delete();
    out_q.delete();
    for (int c = 0; c < NC; c++) core_q[c].delete();
    tick();
    chk("midbatch_reset_outputs", s_ctl, 8'h00);
    $display("mid-batch reset applied at cycle %0d", cyc);
    i_add_rdy = 1'b1;
    run_vec(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multiexp_dispatch_reduce.md
MULTIEXP_DISPATCH_REDUCE -- requirements
Module: multiexp_dispatch_reduce

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4: number of attached multiexp cores, any value 1..16 (no power-of-2 restriction).
REQ-002 SHALL have parameter PNT_BITS, default 768: width of one packed point.
REQ-003 SHALL have parameter SCL_BITS, default 256: width of one scalar.
REQ-004 SHALL have parameter NUM_IN_MAX, default 1024: largest runtime batch size.
REQ-005 SHALL have ports, clock and reset first: i_clk in 1 clock; i_rst in 1 reset, synchronous, active-high.
REQ-006 SHALL have ports i_num_in in clog2(NUM_IN_MAX+1) batch size; i_val, o_rdy in/out 1; i_dat in PNT_BITS+SCL_BITS point-scalar pair; i_eop in 1.
REQ-007 SHALL have ports o_core_val out NUM_CORES; o_core_dat out PNT_BITS+SCL_BITS; o_core_eop out 1; i_core_rdy in NUM_CORES.
REQ-008 SHALL have ports i_res_val in NUM_CORES; i_res_dat in NUM_CORES*PNT_BITS; o_res_rdy out NUM_CORES.
REQ-009 SHALL have ports o_add_val out 1; o_add_dat out 2*PNT_BITS {a,b}; i_add_rdy in 1; i_add_val in 1; i_add_dat in PNT_BITS; o_add_rdy out 1.
REQ-010 SHALL have ports o_val out 1; o_dat out PNT_BITS; o_err out 1; i_rdy in 1.

Function
REQ-011 SHALL implement states IDLE, LOAD, COLLECT, REDUCE, OUT.
- IDLE->LOAD on i_val with i_num_in>0.
- Latch i_num_in as N; ACT=min(N,NUM_CORES).
REQ-012 In LOAD, item k SHALL go to core k mod NUM_CORES, strict round robin.
- o_rdy=i_core_rdy[target].
- No skipping of a stalled core.
REQ-013 o_core_eop SHALL be 1 on the last item delivered to each core, i.e. on items k>=N-ACT.
REQ-014 After item N-1 is accepted, SHALL enter COLLECT.
REQ-015 If i_eop on item k!=N-1, or item N-1 arrives without i_eop, SHALL set sticky err.
- Counting still continues to N.
REQ-016 In COLLECT, SHALL accept results strictly in core order 0..ACT-1.
- o_res_rdy is one-hot on the next core.
- Results from cores >=ACT are never accepted.
REQ-017 The first result SHALL load accumulator acc.
- For each later result r_i, SHALL issue add {acc,r_i} (REDUCE), hold o_add_val until i_add_rdy, then o_add_rdy=1 until i_add_val, then acc<=i_add_dat.
- At most one add outstanding.
REQ-018 After ACT-1 adds (zero when ACT=1), SHALL go to OUT.
- OUT: o_val=1, o_dat=acc, o_err=err, held until i_rdy.
- Then IDLE, clearing err and counters.
REQ-019 o_rdy SHALL be 0 outside LOAD; a new batch cannot start while OUT is pending.
REQ-020 Latency SHALL be OUT one cycle after the accepting add-result cycle, or one cycle after core 0 result when ACT=1.

Reset
REQ-021 On i_rst, all outputs SHALL be 0 (o_rdy, o_core_val, o_core_eop, o_res_rdy, o_add_val, o_add_rdy, o_val, o_err), state=IDLE, counters and acc=0.
REQ-022 Reset mid-batch SHALL abandon the batch; no partial output; next batch starts with item 0 to core 0.

Structure
REQ-023 State enum, point/scalar packing typedefs and the ctl-bit assignments SHALL live in the shared multiexp package.
REQ-024 One sub-module SHALL be natural: multiexp_rr_dispatch (round-robin index, per-core eop, and count logic).

Verification
REQ-025 NUM_CORES=3, N=7, all ready: cores 0/1/2 get 3/2/2 items; eop on k=4,5,6; results P0,P1,P2 -> adds {P0,P1}, {S,P2}; o_dat = P0+P1+P2, o_err=0.
REQ-026 NUM_CORES=4, N=2: only cores 0,1 used; exactly 1 add; cores 2,3 never get val or res_rdy.
REQ-027 i_core_rdy[1]=0 for 10 cycles during LOAD: o_rdy=0 for those cycles; item order preserved, none dropped.
REQ-028 i_eop on k=3 with N=8: o_err=1 with the result; err clears for the next clean batch.
REQ-029 i_rst asserted during REDUCE: all outputs 0 the next cycle; new N=4 batch completes with correct sum.
REQ-030 i_rdy=0 for 5 cycles in OUT: o_val and o_dat stable; o_rdy stays 0.
